// File: rtl/inst_loader.sv
// Program loader: turns a count-prefixed byte stream into 9-bit instruction
// memory writes, holding busy for the whole session so the core stays in reset.
module inst_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       fmt_err
);

    typedef enum logic [1:0] {IDLE, COUNT, LO, HI} state_t;

    state_t     state_q, state_d;
    logic [7:0] addr_cnt;
    logic [8:0] remaining;
    logic [7:0] lo_byte;

    logic hs;
    logic count_fire, lo_fire, hi_fire, last_instr;

    assign hs         = in_valid & in_ready;
    assign count_fire = (state_q == COUNT) && hs && !abort;
    assign lo_fire    = (state_q == LO)    && hs && !abort;
    assign hi_fire    = (state_q == HI)    && hs && !abort;
    assign last_instr = (remaining == 9'd1);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                // start beats a simultaneous abort: abort has no meaning in IDLE
                if (start) state_d = COUNT;
            end
            COUNT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (abort)   state_d = IDLE;
                else if (hs) state_d = LO;
            end
            LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (abort)   state_d = IDLE;
                else if (hs) state_d = HI;
            end
            HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (abort)   state_d = IDLE;
                else if (hs) state_d = last_instr ? IDLE : LO;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_cnt  <= BASE_ADDR;
            remaining <= 9'd0;
            lo_byte   <= 8'd0;
            wr_en     <= 1'b0;
            wr_addr   <= 8'd0;
            wr_data   <= 9'd0;
            done      <= 1'b0;
            fmt_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_en   <= 1'b0;

            if (state_q == IDLE && start) begin
                addr_cnt <= BASE_ADDR;
                done     <= 1'b0;
                fmt_err  <= 1'b0;
            end

            // A count byte of zero stands for a full 256-instruction image
            if (count_fire)
                remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};

            if (lo_fire)
                lo_byte <= in_data;

            if (hi_fire) begin
                wr_en     <= 1'b1;
                wr_addr   <= addr_cnt;
                wr_data   <= {in_data[0], lo_byte};
                addr_cnt  <= addr_cnt + 8'd1;
                remaining <= remaining - 9'd1;
                if (in_data[7:1] != 7'd0) fmt_err <= 1'b1;
                if (last_instr)           done    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: table-driven instruction streams plus
// hand-written sequences for wrap, abort, async reset and start-while-busy.
module tb_inst_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, abort, in_valid;
    logic [7:0] in_data;

    logic       in_ready, wr_en, busy, done, fmt_err;
    logic [7:0] wr_addr;
    logic [8:0] wr_data;

    logic       f_in_ready, f_wr_en, f_busy, f_done, f_fmt_err;
    logic [7:0] f_wr_addr;
    logic [8:0] f_wr_data;

    inst_loader dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .fmt_err(fmt_err)
    );

    inst_loader #(.BASE_ADDR(8'hF0)) dut_f0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(f_in_ready),
        .wr_en(f_wr_en), .wr_addr(f_wr_addr), .wr_data(f_wr_data),
        .busy(f_busy), .done(f_done), .fmt_err(f_fmt_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] addr;
        logic [8:0] data;
        logic       done;
        logic       busy;
    } wr_t;

    typedef struct packed {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [8:0] exp_data;
    } vec_t;

    wr_t  wq0[$];
    wr_t  wqf[$];
    vec_t vec[5];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ready_viol = 0;

    // Capture write strobes on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (wr_en)   wq0.push_back('{wr_addr, wr_data, done, busy});
        if (f_wr_en) wqf.push_back('{f_wr_addr, f_wr_data, f_done, f_busy});
        if (in_ready && !busy) ready_viol++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            n = $urandom_range(2, 0);
            repeat (n) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("handshake_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic start_session();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy",    {31'd0, busy},    32'd1);
        check("start_done",    {31'd0, done},    32'd0);
        check("start_fmt_err", {31'd0, fmt_err}, 32'd0);
    endtask

    task automatic run_session(input int first, input int n, input bit gaps);
        wq0.delete();
        start_session();
        send_byte(8'(n), gaps);
        for (int i = 0; i < n; i++) begin
            send_byte(vec[first + i].lo, gaps);
            send_byte(vec[first + i].hi, gaps);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic verify(input string tag, input int first, input int n, input logic [7:0] base);
        check({tag, "_count"}, wq0.size(), n);
        for (int i = 0; i < n && i < wq0.size(); i++) begin
            check({tag, "_addr"}, {24'd0, wq0[i].addr}, {24'd0, 8'(base + 8'(i))});
            check({tag, "_data"}, {23'd0, wq0[i].data}, {23'd0, vec[first + i].exp_data});
            check({tag, "_done_at_write"}, {31'd0, wq0[i].done}, (i == n - 1) ? 32'd1 : 32'd0);
        end
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        check({tag, "_done_after"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{8'h2A, 8'h01, 9'h12A};
        vec[1] = '{8'hFF, 8'h00, 9'h0FF};
        vec[2] = '{8'h00, 8'h01, 9'h100};
        vec[3] = '{8'h55, 8'h03, 9'h155};
        vec[4] = '{8'h7E, 8'h00, 9'h07E};

        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #2;
        check("reset_outputs", {12'd0, in_ready, wr_en, wr_addr, wr_data, busy, done, fmt_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Scenario 1: three instructions, sustained stream
        run_session(0, 3, 1'b0);
        verify("s1", 0, 3, 8'h00);
        check("s1_fmt_err", {31'd0, fmt_err}, 32'd0);

        // Scenario 2: count 0 means 256, address wraps F0..FF,00..EF
        wqf.delete();
        start_session();
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(8'hF0 + 8'(i)), 1'b0);
            send_byte(8'h00, 1'b0);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("s2_count", wqf.size(), 256);
        for (int i = 0; i < wqf.size(); i++) begin
            check("s2_addr", {24'd0, wqf[i].addr}, {24'd0, 8'(8'hF0 + 8'(i))});
            check("s2_data", {23'd0, wqf[i].data}, {24'd0, 8'(8'hF0 + 8'(i))});
        end
        if (wqf.size() == 256) check("s2_last_done", {31'd0, wqf[255].done}, 32'd1);
        if (wqf.size() == 256) check("s2_255_not_done", {31'd0, wqf[254].done}, 32'd0);
        check("s2_busy_after", {31'd0, f_busy}, 32'd0);

        // Scenario 3: same stream as 1 with random valid gaps
        ready_viol = 0;
        run_session(0, 3, 1'b1);
        verify("s3", 0, 3, 8'h00);
        check("s3_ready_in_idle", ready_viol, 0);

        // Scenario 4: malformed high byte sets sticky fmt_err, write uses bit 0
        run_session(3, 2, 1'b0);
        verify("s4", 3, 2, 8'h00);
        check("s4_fmt_err_sticky", {31'd0, fmt_err}, 32'd1);

        // Scenario 5: abort after the low byte of the second instruction
        wq0.delete();
        start_session();
        send_byte(8'h03, 1'b0);
        send_byte(vec[0].lo, 1'b0);
        send_byte(vec[0].hi, 1'b0);
        send_byte(vec[1].lo, 1'b0);
        abort = 1'b1; in_valid = 1'b1; in_data = vec[1].hi;
        #1;
        check("s5_ready_during_abort", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        check("s5_busy", {31'd0, busy}, 32'd0);
        check("s5_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        check("s5_writes", wq0.size(), 1);
        run_session(1, 2, 1'b0);
        verify("s5_reload", 1, 2, 8'h00);

        // start and abort together in IDLE: session still starts
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle_busy", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_to_idle", {31'd0, busy}, 32'd0);

        // Scenario 6: asynchronous reset while waiting for a high byte
        start_session();
        send_byte(8'h02, 1'b0);
        send_byte(8'h2A, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hFF, 1'b0);
        in_valid = 1'b0;
        check("s6_pre_reset_data", {23'd0, wr_data}, 32'h12A);
        #2 reset = 1'b1;
        #1;
        check("s6_async_reset", {12'd0, in_ready, wr_en, wr_addr, wr_data, busy, done, fmt_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // start pulsed mid-session must not reload the address counter
        wq0.delete();
        start_session();
        send_byte(8'h02, 1'b0);
        send_byte(vec[0].lo, 1'b0);
        send_byte(vec[0].hi, 1'b0);
        start = 1'b1;
        send_byte(vec[1].lo, 1'b0);
        start = 1'b0;
        send_byte(vec[1].hi, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        verify("s6_start_busy", 0, 2, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
Program loader that fills the 256 x 9-bit instruction memory before the core runs.
- Accepts a byte stream over a valid/ready handshake.
- Assembles each 9-bit instruction from two bytes.
- Issues single-cycle write strobes (address, data) into the instruction memory's write port.
- Sits between the host/UART byte source and the instruction memory. Holds busy while loading so the core stays in reset.

Parameters:
BASE_ADDR, 0, first instruction-memory address written after start (8-bit, wraps mod 256)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin a load session; sampled only in IDLE
abort  input  1  cancel an active session; returns to IDLE without done
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts byte this cycle (handshake = in_valid & in_ready)
wr_en  output  1  instruction-memory write strobe, one cycle per instruction
wr_addr  output  8  write address
wr_data  output  9  write data
busy  output  1  session active (COUNT/LO/HI)
done  output  1  last session completed normally; held until next start or reset
fmt_err  output  1  sticky: some high byte had bits [7:1] nonzero; cleared on start

Behaviour:
- Reset (async, any state): state = IDLE, address counter = BASE_ADDR, remaining = 0. All outputs 0.
- States: IDLE, COUNT, LO, HI. in_ready = 1 only in COUNT, LO and HI. in_ready is a pure function of state.
- IDLE:
  - start = 1 -> COUNT next cycle.
  - Same edge: busy set, done and fmt_err cleared, address counter loaded with BASE_ADDR.
- COUNT: on handshake, remaining = in_data, with 0 meaning 256 (9-bit counter) -> LO.
- LO: on handshake, latch low byte -> HI.
- HI: on handshake:
  - Register wr_en = 1, wr_addr = address counter, wr_data = {in_data[0], low byte}. Visible the cycle after the handshake (latency 1).
  - wr_en lasts exactly one cycle.
  - If in_data[7:1] != 0, set fmt_err. The write still occurs using bit 0.
  - Address counter increments with wrap 255 -> 0. remaining decrements.
  - If remaining reaches 0: -> IDLE, busy = 0, done = 1 on the same edge as the final wr_en. Otherwise -> LO.
- No handshake (in_valid = 0): state holds indefinitely; no timeout.
- wr_addr and wr_data hold their last values when wr_en = 0.
- start while busy: ignored.
- abort:
  - In COUNT/LO/HI: -> IDLE next edge, busy = 0, done stays 0. A partially received instruction is discarded, with no write.
  - abort wins over a simultaneous handshake; that byte is not consumed and in_ready is still high that cycle. Sources treat abort as a flush.
  - In IDLE: no effect.
- start and abort together in IDLE: abort is ignored and the session starts.
- Writes at or before the last full HI handshake are committed; no rollback.
- Throughput: one byte per cycle sustained; one instruction per 2 cycles.

Test Plan:
1. BASE_ADDR = 0, start, then bytes 03, 2A, 01, FF, 00, 00, 01 with in_valid held high -> wr_en pulses at addr 0/1/2 with data 0x12A, 0x0FF, 0x100. done = 1 and busy = 0 after the third write. fmt_err = 0.
2. BASE_ADDR = 0xF0, count byte 00 (256 instrs), data = address pattern -> 256 writes with addresses F0..FF then 00..EF (wrap). done after write 256, exactly 256 wr_en pulses.
3. Random in_valid gaps (~50% duty) on scenario 1 stream -> identical writes and data; no byte dropped or duplicated; in_ready never high in IDLE.
4. High byte 0x03 for one instruction -> data bit 8 = 1 written, fmt_err = 1 and stays set through done. The next start clears it.
5. abort asserted after an LO byte of the 2nd of 3 instrs -> only 1 write issued, busy = 0, done = 0. A new start then loads from BASE_ADDR correctly.
6. reset asserted mid-HI (async, between edges) -> outputs 0 immediately, state IDLE. start pulse while busy in a later session is ignored, with no counter reload.
